// File: rtl/spiox_pkg.sv
// spiox_pkg: register map, field layout and reset constants shared by the
// spiox peripheral and its bench.
package spiox_pkg;

    // Register select on the 2-bit Wishbone address
    typedef enum logic [1:0] {
        ADDR_LED  = 2'd0,
        ADDR_IN   = 2'd1,
        ADDR_PEND = 2'd2,
        ADDR_CTRL = 2'd3
    } reg_addr_e;

    // IN register layout
    localparam int IN_BTN_OFF    = 0;
    localparam int IN_SW_OFF     = 8;

    // PEND register layout (enables in CTRL use the same offsets)
    localparam int PEND_BTN_OFF  = 0;
    localparam int PEND_BTN_W    = 8;
    localparam int PEND_SW_OFF   = 8;
    localparam int PEND_SW_W     = 8;

    // CTRL register layout
    localparam int CTRL_EN_OFF   = 0;
    localparam int CTRL_EN_W     = 16;
    localparam int CTRL_DUTY_OFF = 16;
    localparam int CTRL_DUTY_W   = 8;
    localparam int CTRL_DEMO_BIT = 24;

    // Reset values: full brightness, demo sweep running
    localparam logic [7:0] DUTY_RST = 8'hff;
    localparam logic       DEMO_RST = 1'b1;

endpackage

// File: rtl/spiox_if.sv
// spiox_if: pipelined Wishbone slave bundle for the spiox peripheral.
interface spiox_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_data
    );
endinterface

// File: rtl/spiox_debounce.sv
// spiox_debounce: 2FF synchroniser, shared tick counter and a two-sample
// stability filter. A bit only changes when the synchronised value matched
// the sample taken at the previous tick.
module spiox_debounce #(
    parameter int N           = 8,
    parameter int DEBOUNCE_LG = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] raw,
    output logic [N-1:0] deb
);

    logic [N-1:0]           sync_1;
    logic [N-1:0]           sync_2;
    logic [N-1:0]           sample;
    logic [N-1:0]           differs;
    logic [DEBOUNCE_LG-1:0] tick_cnt;
    logic                   tick;

    assign tick    = &tick_cnt;
    assign differs = sync_2 ^ sample;

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Free-running tick counter; a tick is the cycle in which it wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt <= '0;
        else        tick_cnt <= tick_cnt + 1'b1;
    end

    // On each tick, accept bits that held their value since the last tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= '0;
            deb    <= '0;
        end else if (tick) begin
            sample <= sync_2;
            deb    <= (sync_2 & ~differs) | (deb & differs);
        end
    end

endmodule

// File: rtl/spiox.sv
// spiox: Wishbone peripheral driving LEDs (masked writes, PWM, demo sweep),
// debouncing buttons, synchronising switches and raising a level interrupt
// from per-source pending bits.
module spiox
    import spiox_pkg::*;
#(
    parameter int NLEDS       = 8,
    parameter int NBTN        = 8,
    parameter int NSW         = 8,
    parameter int DEBOUNCE_LG = 16,
    parameter int DEMO_LG     = 22
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    spiox_if.slave           wb,
    input  logic [NSW-1:0]   i_sw,
    input  logic [NBTN-1:0]  i_btn,
    output logic [NLEDS-1:0] o_led,
    output logic             o_int
);

    localparam int POS_W = (NLEDS > 1) ? $clog2(NLEDS) : 1;

    reg_addr_e          addr;
    logic               wr, wr_led, wr_pend, wr_ctrl;
    logic [31:0]        rd_data;

    logic [NLEDS-1:0]   led_reg, led_next;
    logic [NBTN-1:0]    btn_deb, btn_deb_q;
    logic [NSW-1:0]     sw_s1, sw_s2, sw_q;
    logic [NBTN-1:0]    pend_btn, pend_btn_next, en_btn;
    logic [NSW-1:0]     pend_sw, pend_sw_next, en_sw;
    logic [15:0]        pend_clr;
    logic [7:0]         duty;
    logic               demo;

    logic [7:0]         pwm_cnt;
    logic               pwm_on;
    logic [DEMO_LG-1:0] demo_cnt;
    logic [POS_W-1:0]   demo_pos;
    logic               demo_down;
    logic [NLEDS-1:0]   sweep;

    assign addr    = reg_addr_e'(wb.i_wb_addr);
    assign wr      = wb.i_wb_cyc & wb.i_wb_stb & wb.i_wb_we;
    assign wr_led  = wr && (addr == ADDR_LED);
    assign wr_pend = wr && (addr == ADDR_PEND);
    assign wr_ctrl = wr && (addr == ADDR_CTRL);

    assign wb.o_wb_stall = 1'b0;

    spiox_debounce #(
        .N           (NBTN),
        .DEBOUNCE_LG (DEBOUNCE_LG)
    ) u_debounce (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .raw   (i_btn),
        .deb   (btn_deb)
    );

    // Switch synchroniser plus a one-clock delayed copy for change detection
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            sw_q  <= '0;
        end else begin
            sw_s1 <= i_sw;
            sw_s2 <= sw_s1;
            sw_q  <= sw_s2;
        end
    end

    // LED register next value: whole load or per-bit masked update
    always_comb begin
        // NOTE: default first so every path assigns led_next and no latch forms.
        led_next = led_reg;
        if (wr_led) begin
            if (wb.i_wb_sel[0] && wb.i_wb_sel[1] && (wb.i_wb_data[31:16] == 16'h0)) begin
                led_next = wb.i_wb_data[NLEDS-1:0];
            end else begin
                for (int i = 0; i < NLEDS; i++) begin
                    if (wb.i_wb_sel[i/8] && wb.i_wb_sel[2 + i/8] && wb.i_wb_data[16 + i])
                        led_next[i] = wb.i_wb_data[i];
                end
            end
        end
    end

    // Pending next value: W1C clear per selected byte, new events win
    always_comb begin
        pend_clr = '0;
        if (wr_pend)
            pend_clr = wb.i_wb_data[15:0] & {{8{wb.i_wb_sel[1]}}, {8{wb.i_wb_sel[0]}}};
        pend_btn_next = (pend_btn & ~pend_clr[PEND_BTN_OFF +: NBTN]) | (btn_deb & ~btn_deb_q);
        pend_sw_next  = (pend_sw  & ~pend_clr[PEND_SW_OFF  +: NSW])  | (sw_s2 ^ sw_q);
    end

    // Read mux; unused and unimplemented bits read as zero
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_LED:  rd_data[NLEDS-1:0] = led_reg;
            ADDR_IN: begin
                rd_data[IN_BTN_OFF +: NBTN] = btn_deb;
                rd_data[IN_SW_OFF  +: NSW]  = sw_s2;
            end
            ADDR_PEND: begin
                rd_data[PEND_BTN_OFF +: NBTN] = pend_btn;
                rd_data[PEND_SW_OFF  +: NSW]  = pend_sw;
            end
            ADDR_CTRL: begin
                rd_data[CTRL_EN_OFF + PEND_BTN_OFF +: NBTN] = en_btn;
                rd_data[CTRL_EN_OFF + PEND_SW_OFF  +: NSW]  = en_sw;
                rd_data[CTRL_DUTY_OFF +: CTRL_DUTY_W]       = duty;
                rd_data[CTRL_DEMO_BIT]                      = demo;
            end
            default:   rd_data = '0;
        endcase
    end

    // Register file, bus response and interrupt output
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            led_reg      <= '0;
            pend_btn     <= '0;
            pend_sw      <= '0;
            en_btn       <= '0;
            en_sw        <= '0;
            duty         <= DUTY_RST;
            demo         <= DEMO_RST;
            btn_deb_q    <= '0;
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= '0;
            o_int        <= 1'b0;
        end else begin
            led_reg   <= led_next;
            pend_btn  <= pend_btn_next;
            pend_sw   <= pend_sw_next;
            btn_deb_q <= btn_deb;
            if (wr_ctrl) begin
                if (wb.i_wb_sel[0]) en_btn <= wb.i_wb_data[CTRL_EN_OFF + PEND_BTN_OFF +: NBTN];
                if (wb.i_wb_sel[1]) en_sw  <= wb.i_wb_data[CTRL_EN_OFF + PEND_SW_OFF  +: NSW];
                if (wb.i_wb_sel[2]) duty   <= wb.i_wb_data[CTRL_DUTY_OFF +: CTRL_DUTY_W];
                if (wb.i_wb_sel[3]) demo   <= wb.i_wb_data[CTRL_DEMO_BIT];
            end
            wb.o_wb_ack <= wb.i_wb_stb;
            if (wb.i_wb_stb) wb.o_wb_data <= rd_data;
            o_int <= |({pend_sw, pend_btn} & {en_sw, en_btn});
        end
    end

    // Demo sweep: ping-pong a single lit bit, one step per counter wrap
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            demo_cnt  <= '0;
            demo_pos  <= '0;
            demo_down <= 1'b0;
        end else begin
            demo_cnt <= demo_cnt + 1'b1;
            if ((&demo_cnt) && (NLEDS > 1)) begin
                if (!demo_down) begin
                    if (demo_pos == POS_W'(NLEDS - 1)) begin
                        demo_down <= 1'b1;
                        demo_pos  <= demo_pos - 1'b1;
                    end else begin
                        demo_pos  <= demo_pos + 1'b1;
                    end
                end else begin
                    if (demo_pos == '0) begin
                        demo_down <= 1'b0;
                        demo_pos  <= demo_pos + 1'b1;
                    end else begin
                        demo_pos  <= demo_pos - 1'b1;
                    end
                end
            end
        end
    end

    assign sweep  = NLEDS'(1) << demo_pos;
    assign pwm_on = (duty == 8'hff) || (pwm_cnt < duty);

    // PWM counter and registered LED drive
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt <= '0;
            o_led   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            o_led   <= (demo ? sweep : led_reg) & {NLEDS{pwm_on}};
        end
    end

endmodule

// File: tb/tb_spiox.sv
// tb_spiox: directed, table-driven bench for spiox with short debounce and
// demo periods so tick-related behaviour is reachable in a few hundred clocks.
module tb_spiox;
    import spiox_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic [7:0] btn;
    logic [7:0] led;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    spiox_if wb ();

    spiox #(
        .NLEDS       (8),
        .NBTN        (8),
        .NSW         (8),
        .DEBOUNCE_LG (4),
        .DEMO_LG     (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .wb        (wb),
        .i_sw      (sw),
        .i_btn     (btn),
        .o_led     (led),
        .o_int     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle, starting just after a rising edge; returns just after the next
    task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [31:0] data,
                            input logic [3:0] sel, output logic [31:0] rdata, output logic ack);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = we;
        wb.i_wb_addr = addr;
        wb.i_wb_data = data;
        wb.i_wb_sel  = sel;
        @(posedge clk); #1;
        ack   = wb.o_wb_ack;
        rdata = wb.o_wb_data;
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
        wb.i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input string name, input logic [1:0] addr, input logic [31:0] data,
                            input logic [3:0] sel);
        logic [31:0] r;
        logic        a;
        bus_xfer(1'b1, addr, data, sel, r, a);
        check({name, " ack"}, {31'b0, a}, 32'd1);
    endtask

    task automatic wb_read(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        a;
        bus_xfer(1'b0, addr, 32'h0, 4'hf, r, a);
        check({name, " ack"}, {31'b0, a}, 32'd1);
        check(name, r, exp);
    endtask

    task automatic add_vec(input string name, input logic we, input logic [1:0] addr,
                           input logic [31:0] data, input logic [3:0] sel, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.data = data; v.sel = sel; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int hi;
        int other;

        // Register vectors, applied in order right after reset
        add_vec("rd LED rst",      1'b0, ADDR_LED,  32'h0,        4'hf, 32'h0000_0000);
        add_vec("rd IN rst",       1'b0, ADDR_IN,   32'h0,        4'hf, 32'h0000_0000);
        add_vec("rd PEND rst",     1'b0, ADDR_PEND, 32'h0,        4'hf, 32'h0000_0000);
        add_vec("rd CTRL rst",     1'b0, ADDR_CTRL, 32'h0,        4'hf, 32'h01ff_0000);
        add_vec("wr CTRL demo off",1'b1, ADDR_CTRL, 32'h00ff_0000,4'hf, 32'h0);
        add_vec("rd CTRL demo off",1'b0, ADDR_CTRL, 32'h0,        4'hf, 32'h00ff_0000);
        add_vec("wr CTRL duty byte",1'b1,ADDR_CTRL, 32'hff33_ffff,4'h4, 32'h0);
        add_vec("rd CTRL duty byte",1'b0,ADDR_CTRL, 32'h0,        4'hf, 32'h0033_0000);
        add_vec("wr CTRL all",     1'b1, ADDR_CTRL, 32'hffff_ffff,4'hf, 32'h0);
        add_vec("rd CTRL all",     1'b0, ADDR_CTRL, 32'h0,        4'hf, 32'h01ff_ffff);
        add_vec("wr CTRL restore", 1'b1, ADDR_CTRL, 32'h00ff_0000,4'hf, 32'h0);
        add_vec("rd CTRL restore", 1'b0, ADDR_CTRL, 32'h0,        4'hf, 32'h00ff_0000);
        add_vec("wr LED a5",       1'b1, ADDR_LED,  32'h0000_00a5,4'hf, 32'h0);
        add_vec("rd LED a5",       1'b0, ADDR_LED,  32'h0,        4'hf, 32'h0000_00a5);
        add_vec("wr LED byte0 only",1'b1,ADDR_LED,  32'h0000_00ff,4'h1, 32'h0);
        add_vec("rd LED byte0 only",1'b0,ADDR_LED,  32'h0,        4'hf, 32'h0000_00a5);
        add_vec("wr LED mask hi",  1'b1, ADDR_LED,  32'h00f0_000f,4'hf, 32'h0);
        add_vec("rd LED mask hi",  1'b0, ADDR_LED,  32'h0,        4'hf, 32'h0000_0005);
        add_vec("wr IN ignored",   1'b1, ADDR_IN,   32'hffff_ffff,4'hf, 32'h0);
        add_vec("rd IN ignored",   1'b0, ADDR_IN,   32'h0,        4'hf, 32'h0000_0000);
        add_vec("wr PEND idle",    1'b1, ADDR_PEND, 32'hffff_ffff,4'hf, 32'h0);
        add_vec("rd PEND idle",    1'b0, ADDR_PEND, 32'h0,        4'hf, 32'h0000_0000);

        rst_n        = 1'b0;
        sw           = '0;
        btn          = '0;
        wb.i_wb_cyc  = 1'b0;
        wb.i_wb_stb  = 1'b0;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = '0;
        wb.i_wb_data = '0;
        wb.i_wb_sel  = '0;

        #20;
        check("reset o_led", {24'b0, led}, 32'h0);
        check("reset ack", {31'b0, wb.o_wb_ack}, 32'h0);
        check("reset o_int", {31'b0, irq}, 32'h0);
        check("reset stall", {31'b0, wb.o_wb_stall}, 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Demo sweep at full duty: bit 0 lit, moves to bit 1 after 16 clocks
        check("sweep start", {24'b0, led}, 32'h01);
        n = 0;
        while (led == 8'h01 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("sweep step value", {24'b0, led}, 32'h02);
        check("sweep step clocks", n, 16);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].we) wb_write(vecs[k].name, vecs[k].addr, vecs[k].data, vecs[k].sel);
            else            wb_read(vecs[k].name, vecs[k].addr, vecs[k].exp);
        end

        // Masked LED write and its two-clock path to o_led
        wb_write("led full a5", ADDR_LED, 32'h0000_00a5, 4'hf);
        repeat (2) @(posedge clk);
        #1;
        check("o_led a5", {24'b0, led}, 32'ha5);
        wb_write("led masked", ADDR_LED, 32'h0003_0002, 4'hf);
        check("o_led 1 clk after", {24'b0, led}, 32'ha5);
        @(posedge clk); #1;
        check("o_led 2 clk after", {24'b0, led}, 32'ha6);
        wb_read("rd LED a6", ADDR_LED, 32'h0000_00a6);

        // Short button glitch never debounces
        btn[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1 btn[2] = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        wb_read("PEND after glitch", ADDR_PEND, 32'h0);
        wb_read("IN after glitch", ADDR_IN, 32'h0);

        // Held press: two matching ticks, then PEND, then o_int
        wb_write("en btn2", ADDR_CTRL, 32'h00ff_0004, 4'hf);
        btn[2] = 1'b1;
        n = 0;
        while (!irq && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (!irq || n < 21 || n > 36) begin
            n_errors++;
            $display("FAIL press latency: o_int=%0b after %0d clocks, required 1 within 21..36", irq, n);
        end
        wb_read("PEND after press", ADDR_PEND, 32'h0000_0004);
        wb_read("IN after press", ADDR_IN, 32'h0000_0004);
        wb_write("clear btn2", ADDR_PEND, 32'h0000_0004, 4'hf);
        check("o_int 1 clk after clear", {31'b0, irq}, 32'h1);
        @(posedge clk); #1;
        check("o_int 2 clk after clear", {31'b0, irq}, 32'h0);
        wb_read("PEND after clear", ADDR_PEND, 32'h0);
        btn[2] = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        wb_read("PEND after release", ADDR_PEND, 32'h0);
        wb_read("IN after release", ADDR_IN, 32'h0);

        // Switch change lands on the same clock as a W1C of that bit
        wb_write("en off", ADDR_CTRL, 32'h00ff_0000, 4'hf);
        sw[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb_write("w1c collide", ADDR_PEND, 32'h0000_0100, 4'hf);
        wb_read("PEND set wins", ADDR_PEND, 32'h0000_0100);
        wb_read("IN switch", ADDR_IN, 32'h0000_0100);
        wb_write("w1c sw0", ADDR_PEND, 32'h0000_0100, 4'hf);
        wb_read("PEND sw0 cleared", ADDR_PEND, 32'h0);

        // PWM: quarter duty gives 64 of 256 lit clocks, zero duty none
        wb_write("led ff", ADDR_LED, 32'h0000_00ff, 4'hf);
        wb_write("duty 40", ADDR_CTRL, 32'h0040_0000, 4'hf);
        repeat (3) @(posedge clk);
        #1;
        hi = 0; other = 0;
        for (int c = 0; c < 256; c++) begin
            @(posedge clk); #1;
            if (led == 8'hff) hi++;
            else if (led != 8'h00) other++;
        end
        check("pwm 40 high clocks", hi, 64);
        check("pwm 40 partial", other, 0);
        wb_write("duty 0", ADDR_CTRL, 32'h0000_0000, 4'hf);
        repeat (3) @(posedge clk);
        #1;
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            @(posedge clk); #1;
            if (led != 8'h00) hi++;
        end
        check("pwm 0 lit clocks", hi, 0);

        // Async reset in the middle of a transfer
        wb_write("en sw0 full duty", ADDR_CTRL, 32'h00ff_0100, 4'hf);
        sw[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre-reset o_int", {31'b0, irq}, 32'h1);
        check("pre-reset o_led", {24'b0, led}, 32'hff);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = ADDR_CTRL;
        @(posedge clk); #1;
        check("pre-reset ack", {31'b0, wb.o_wb_ack}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async ack", {31'b0, wb.o_wb_ack}, 32'h0);
        check("async o_int", {31'b0, irq}, 32'h0);
        check("async o_led", {24'b0, led}, 32'h0);
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
        sw[0] = 1'b1;
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read("LED after reset", ADDR_LED, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        wb_read("PEND high sw at release", ADDR_PEND, 32'h0000_0100);
        wb_read("CTRL after reset", ADDR_CTRL, 32'h01ff_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
